sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single 8-bit port of the sdram controller between three requesters:
//  - ROM loader byte writes (hps_io download).
//  - GBA cartridge ROM reads.
//  - Backup/save memory read/write.
//  Commands are aligned to the controller's clkref command slot. Sits between
//  emu top-level glue and the sdram instance; replaces the ad-hoc downloading ?: muxing.
// PARAMETERS
//  ADDR_W      25  byte address width of every port and of mem_addr
//  DATA_LAT    2   clk_sys cycles from command end (slot) to valid mem_dout
//  STARVE_MAX  4   consecutive cart grants allowed while bk_req pending
// PORTS
//  clk_sys     in   1       system clock; all logic on its rising edge
//  reset       in   1       synchronous, active-high
//  slot        in   1       1-cycle pulse, one per sdram command slot (period >= 4)
//  ld_req      in   1       loader write request (level; held until ack)
//  ld_addr     in   ADDR_W  loader byte address
//  ld_data     in   8       loader byte
//  ld_ack      out  1       1-cycle pulse: write accepted by sdram
//  cart_req    in   1       cartridge read request
//  cart_addr   in   ADDR_W  cartridge byte address
//  cart_ack    out  1       1-cycle pulse: cart_rdata valid
//  cart_rdata  out  8       read data, held until next cart_ack
//  bk_req      in   1       backup request
//  bk_we       in   1       1 = write, 0 = read
//  bk_addr     in   ADDR_W  backup byte address
//  bk_wdata    in   8       backup write byte
//  bk_ack      out  1       1-cycle pulse: done (read: bk_rdata valid)
//  bk_rdata    out  8       read data, held until next bk_ack
//  mem_addr    out  ADDR_W  to sdram .addr
//  mem_we      out  1       to sdram .we
//  mem_oe      out  1       to sdram .oeA
//  mem_din     out  8       to sdram .din
//  mem_dout    in   8       from sdram .doutA
//  busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset values:
//  - All outputs 0.
//  - State IDLE, starvation counter 0, grant register = none.
//  - Reset mid-transaction drops it: no ack is issued; mem_we/mem_oe go 0
//    the cycle after reset is sampled.
//  FSM IDLE -> CMD -> WAIT -> IDLE:
//  - IDLE: on a slot cycle with any unmasked req, pick a winner and latch its
//    addr/data/we. Next cycle -> CMD.
//  - CMD: mem_addr/mem_din driven from the latch; exactly one of mem_we/mem_oe = 1.
//    Held until the next slot pulse inclusive.
//    - Write: ack pulses in the cycle after that slot, then -> IDLE.
//    - Read: -> WAIT.
//  - WAIT: count DATA_LAT cycles after the slot, then capture mem_dout into the
//    rdata register. Ack in that same cycle; -> IDLE.
//  Ack / re-request:
//  - Requester addr/data must be stable from req rise until grant; later
//    changes are ignored.
//  - Dropping req after grant does not cancel; ack is still issued.
//  - The acked requester's req is masked in the ack cycle and the following
//    cycle, so a lingering req is never served twice.
//  Priority:
//  - ld > cart > bk.
//  - After STARVE_MAX consecutive cart grants with bk_req pending, bk wins the
//    next non-loader arbitration.
//  - Counter resets on any bk grant or when bk_req is low. It is frozen while
//    ld wins.
//  Throughput: at most one transaction per two slots.
//  Simultaneous slot and ack cycle: the slot is not used for arbitration
//  (FSM not in IDLE).
//  Address arithmetic: none; addresses pass through unmodified at full ADDR_W.
// CONFIGURATION
//  SDRAM_ARB_STATS_EN defined:
//  - Adds outputs ld_cnt, cart_cnt, bk_cnt (16-bit each).
//  - Each increments on its requester's ack, saturates at 16'hFFFF, and is
//    cleared by reset.
//  Not defined: these ports and counters do not exist; behaviour is otherwise
//  identical.
// TESTING
//  1. ld_req, ld_addr=0x00015, ld_data=0xA5 -> one CMD with mem_we=1,
//     mem_addr=0x00015, mem_din=0xA5; ld_ack 1 cycle after next slot.
//  2. cart_req, addr=0x1FFFF, model returns 0x3C -> mem_oe=1;
//     cart_ack/cart_rdata=0x3C exactly DATA_LAT cycles after end slot.
//  3. ld_req, cart_req, bk_req all rise together -> grant order ld, cart, bk;
//     one ack each, no duplicates.
//  4. cart_req held continuously, bk_req held -> 4 cart acks, then 1 bk ack,
//     then cart resumes.
//  5. reset asserted in WAIT of a cart read -> no cart_ack; all outputs 0
//     next cycle; next request served normally.
//  6. With SDRAM_ARB_STATS_EN: 3 ld + 2 cart acks -> ld_cnt=3, cart_cnt=2,
//     bk_cnt=0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Request/response and sdram-side signals of the three-way sdram port arbiter.
// slave: arbiter side; master: requesters plus sdram controller side.
interface sdram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ack;

  logic              cart_req;
  logic [ADDR_W-1:0] cart_addr;
  logic              cart_ack;
  logic [7:0]        cart_rdata;

  logic              bk_req;
  logic              bk_we;
  logic [ADDR_W-1:0] bk_addr;
  logic [7:0]        bk_wdata;
  logic              bk_ack;
  logic [7:0]        bk_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_oe;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

  modport slave (
    input  ld_req, ld_addr, ld_data,
    output ld_ack,
    input  cart_req, cart_addr,
    output cart_ack, cart_rdata,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    output bk_ack, bk_rdata,
    output mem_addr, mem_we, mem_oe, mem_din,
    input  mem_dout
  );

  modport master (
    output ld_req, ld_addr, ld_data,
    input  ld_ack,
    output cart_req, cart_addr,
    input  cart_ack, cart_rdata,
    output bk_req, bk_we, bk_addr, bk_wdata,
    input  bk_ack, bk_rdata,
    input  mem_addr, mem_we, mem_oe, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the 8-bit sdram port between ROM loader, cartridge reads and backup memory,
// with commands aligned to the slot pulse. Optional SDRAM_ARB_STATS_EN adds ack counters.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_LAT   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  slot,
  sdram_port_arbiter_if.slave   bus,
  output logic                  busy
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]           ld_cnt,
  output logic [15:0]           cart_cnt,
  output logic [15:0]           bk_cnt
`endif
);

  localparam int unsigned LAT_W = $clog2(DATA_LAT + 1) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 2);
  localparam logic [LAT_W-1:0] LAT_RD  = LAT_W'(DATA_LAT);
  localparam logic [LAT_W-1:0] LAT_WR  = LAT_W'(1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StCmd, StWait} state_t;
  typedef enum logic [1:0] {GntNone, GntLd, GntCart, GntBk} gnt_t;

  state_t           state_q;
  gnt_t             gnt_q;
  gnt_t             mask_gnt_q;
  logic [1:0]       mask_q;
  logic             we_q;
  logic [LAT_W-1:0] lat_q;
  logic [STV_W-1:0] starve_q;

  logic             ld_ok, cart_ok, bk_ok;
  gnt_t             win;
  logic [LAT_W-1:0] ack_at;
  logic             ack_fire;

  // A requester just acked is ignored for two cycles so a lingering req is not re-served.
  always_comb begin
    ld_ok   = bus.ld_req   && !((mask_q != 2'd0) && (mask_gnt_q == GntLd));
    cart_ok = bus.cart_req && !((mask_q != 2'd0) && (mask_gnt_q == GntCart));
    bk_ok   = bus.bk_req   && !((mask_q != 2'd0) && (mask_gnt_q == GntBk));
    win = GntNone;
    if (ld_ok)                              win = GntLd;
    else if (bk_ok && starve_q >= STV_MAX)  win = GntBk;
    else if (cart_ok)                       win = GntCart;
    else if (bk_ok)                         win = GntBk;
  end

  // lat_q counts cycles since the command-ending slot; ack lands when it reaches ack_at.
  always_comb begin
    ack_at   = we_q ? LAT_WR : LAT_RD;
    ack_fire = ((state_q == StCmd) && slot && (ack_at == LAT_WR)) ||
               ((state_q == StWait) && (lat_q != ack_at) && ((lat_q + LAT_W'(1)) == ack_at));
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= StIdle;
      gnt_q          <= GntNone;
      mask_gnt_q     <= GntNone;
      mask_q         <= 2'd0;
      we_q           <= 1'b0;
      lat_q          <= '0;
      starve_q       <= '0;
      bus.ld_ack     <= 1'b0;
      bus.cart_ack   <= 1'b0;
      bus.cart_rdata <= 8'h00;
      bus.bk_ack     <= 1'b0;
      bus.bk_rdata   <= 8'h00;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_oe     <= 1'b0;
      bus.mem_din    <= 8'h00;
    end else begin
      bus.ld_ack   <= 1'b0;
      bus.cart_ack <= 1'b0;
      bus.bk_ack   <= 1'b0;
      if (mask_q != 2'd0) mask_q <= mask_q - 2'd1;
      if (!bus.bk_req) starve_q <= '0;

      unique case (state_q)
        StIdle: begin
          if (slot && (win != GntNone)) begin
            state_q <= StCmd;
            gnt_q   <= win;
            unique case (win)
              GntLd: begin
                bus.mem_addr <= ADDR_W'(bus.ld_addr);
                bus.mem_din  <= bus.ld_data;
                bus.mem_we   <= 1'b1;
                bus.mem_oe   <= 1'b0;
                we_q         <= 1'b1;
              end
              GntCart: begin
                bus.mem_addr <= ADDR_W'(bus.cart_addr);
                bus.mem_din  <= 8'h00;
                bus.mem_we   <= 1'b0;
                bus.mem_oe   <= 1'b1;
                we_q         <= 1'b0;
                if (bus.bk_req && starve_q != STV_MAX) starve_q <= starve_q + STV_W'(1);
              end
              GntBk: begin
                bus.mem_addr <= ADDR_W'(bus.bk_addr);
                bus.mem_din  <= bus.bk_wdata;
                bus.mem_we   <= bus.bk_we;
                bus.mem_oe   <= !bus.bk_we;
                we_q         <= bus.bk_we;
                starve_q     <= '0;
              end
              default: ;
            endcase
          end
        end
        StCmd: begin
          if (slot) begin
            bus.mem_we <= 1'b0;
            bus.mem_oe <= 1'b0;
            lat_q      <= LAT_WR;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (lat_q == ack_at) begin
            state_q <= StIdle;
            gnt_q   <= GntNone;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      if (ack_fire) begin
        mask_gnt_q <= gnt_q;
        mask_q     <= 2'd2;
        unique case (gnt_q)
          GntLd: bus.ld_ack <= 1'b1;
          GntCart: begin
            bus.cart_ack   <= 1'b1;
            bus.cart_rdata <= bus.mem_dout;
          end
          GntBk: begin
            bus.bk_ack <= 1'b1;
            if (!we_q) bus.bk_rdata <= bus.mem_dout;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ld_cnt   <= 16'h0000;
      cart_cnt <= 16'h0000;
      bk_cnt   <= 16'h0000;
    end else begin
      if (bus.ld_ack   && ld_cnt   != 16'hFFFF) ld_cnt   <= ld_cnt + 16'd1;
      if (bus.cart_ack && cart_cnt != 16'hFFFF) cart_cnt <= cart_cnt + 16'd1;
      if (bus.bk_ack   && bk_cnt   != 16'hFFFF) bk_cnt   <= bk_cnt + 16'd1;
    end
  end
`endif

endmodule
